window_5x5_gen: RTL and testbench

//  Converts a raster-order 8-bit pixel stream into packed 5x5 neighbourhood windows.

---
 rtl/window_5x5_gen.sv | 112 +++++++++++
 tb/tb_window_5x5_gen.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_5x5_gen.sv
// Raster-order 8-bit pixel stream to packed 5x5 neighbourhood windows.
// Four line buffers plus a 5x5 shift window; only fully populated windows are emitted.
module window_5x5_gen #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_pixel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [199:0] out_window,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last
);

    localparam int unsigned PIX_W = 8;
    localparam int unsigned WIN_N = 5;
    localparam int unsigned LB_N  = 4;
    localparam int unsigned WIN_W = PIX_W * WIN_N * WIN_N;
    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [PIX_W-1:0] r_lb [LB_N][IMG_WIDTH];
    logic [WIN_W-1:0] r_win;
    logic [WIN_W-1:0] r_out_window;
    logic             r_out_valid;
    logic             r_out_last;

    logic                        w_xfer;
    logic                        w_eol;
    logic                        w_eof;
    logic                        w_emit;
    logic [WIN_N-1:0][PIX_W-1:0] w_column;
    logic [WIN_W-1:0]            w_win_next;

    assign in_ready   = !r_out_valid || out_ready;
    assign out_window = r_out_window;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;

    assign w_xfer = in_valid && in_ready;
    assign w_eol  = (r_col == COL_W'(IMG_WIDTH - 1));
    assign w_eof  = w_eol && (r_row == ROW_W'(IMG_HEIGHT - 1));
    // A window is complete once four earlier rows and four earlier columns of this frame exist.
    assign w_emit = (r_row >= ROW_W'(4)) && (r_col >= COL_W'(4));

    // Incoming column: oldest buffered row on top, live pixel at the bottom.
    always_comb begin
        w_column    = '0;
        w_column[0] = r_lb[0][r_col];
        w_column[1] = r_lb[1][r_col];
        w_column[2] = r_lb[2][r_col];
        w_column[3] = r_lb[3][r_col];
        w_column[4] = in_pixel;
    end

    // Window shifted left by one column with the new column entering at c=4.
    always_comb begin
        w_win_next = r_win;
        for (int r = 0; r < WIN_N; r++) begin
            for (int c = 0; c < WIN_N - 1; c++) begin
                w_win_next[PIX_W*(WIN_N*r+c) +: PIX_W] = r_win[PIX_W*(WIN_N*r+c+1) +: PIX_W];
            end
            w_win_next[PIX_W*(WIN_N*r+WIN_N-1) +: PIX_W] = w_column[r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_xfer) begin
            if (w_eol) begin
                r_col <= '0;
                r_row <= w_eof ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Storage is never cleared: the emit rule guarantees every byte read out was written this frame.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_lb[0][r_col] <= r_lb[1][r_col];
            r_lb[1][r_col] <= r_lb[2][r_col];
            r_lb[2][r_col] <= r_lb[3][r_col];
            r_lb[3][r_col] <= in_pixel;
            r_win          <= w_win_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_window <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
        end else if (w_xfer && w_emit) begin
            r_out_window <= w_win_next;
            r_out_valid  <= 1'b1;
            r_out_last   <= w_eof;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_5x5_gen.sv
// Bench for window_5x5_gen: two instances (8x6 and 16x9) checked against an array-based window model.
module tb_window_5x5_gen;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic         a_rst, a_iv, a_ir, a_ov, a_or, a_last;
    logic [7:0]   a_pix;
    logic [199:0] a_win;
    logic         b_rst, b_iv, b_ir, b_ov, b_or, b_last;
    logic [7:0]   b_pix;
    logic [199:0] b_win;

    window_5x5_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(6)) u_dut_a (
        .clk(clk), .rst(a_rst), .in_pixel(a_pix), .in_valid(a_iv), .in_ready(a_ir),
        .out_window(a_win), .out_valid(a_ov), .out_ready(a_or), .out_last(a_last)
    );

    window_5x5_gen #(.IMG_WIDTH(16), .IMG_HEIGHT(9)) u_dut_b (
        .clk(clk), .rst(b_rst), .in_pixel(b_pix), .in_valid(b_iv), .in_ready(b_ir),
        .out_window(b_win), .out_valid(b_ov), .out_ready(b_or), .out_last(b_last)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   img [0:8][0:15];
    logic [199:0] exp_win[$];
    logic         exp_last[$];
    logic [199:0] a_got_win[$];
    logic         a_got_last[$];
    logic [199:0] b_got_win[$];
    logic         b_got_last[$];
    bit           b_done;

    always @(posedge clk) begin
        if (!a_rst && a_ov && a_or) begin
            a_got_win.push_back(a_win);
            a_got_last.push_back(a_last);
        end
        if (!b_rst && b_ov && b_or) begin
            b_got_win.push_back(b_win);
            b_got_last.push_back(b_last);
        end
    end

    // Reference: every window is a direct 5x5 slice of the stored image.
    task automatic build_expected(input int w, input int h);
        exp_win.delete();
        exp_last.delete();
        for (int y = 4; y < h; y++) begin
            for (int x = 4; x < w; x++) begin
                logic [199:0] win;
                win = '0;
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++)
                        win[8*(5*r+c) +: 8] = img[y-4+r][x-4+c];
                exp_win.push_back(win);
                exp_last.push_back((y == h-1) && (x == w-1));
            end
        end
    endtask

    task automatic fill_ramp(input int w, input int h, input logic [7:0] base);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                img[y][x] = base + 8'(16*y + x);
    endtask

    task automatic send_a(input logic [7:0] p);
        bit ok;
        ok = 1'b0;
        a_pix = p;
        a_iv  = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = a_ir;
            @(posedge clk);
            #1;
        end
        a_iv = 1'b0;
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_a timeout: in_ready=%b required 1", a_ir);
        end
    endtask

    task automatic send_b(input logic [7:0] p);
        bit ok;
        ok = 1'b0;
        b_pix = p;
        b_iv  = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = b_ir;
            @(posedge clk);
            #1;
        end
        b_iv = 1'b0;
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_b timeout: in_ready=%b required 1", b_ir);
        end
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        a_rst = 1'b1; b_rst = 1'b1;
        a_iv = 1'b0; b_iv = 1'b0; a_pix = '0; b_pix = '0;
        a_or = 1'b1; b_or = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0;
        n_checks++;
        if (a_ov !== 1'b0 || a_last !== 1'b0) begin
            n_errors++; $display("FAIL reset_a_valid: valid=%b last=%b required 0 0", a_ov, a_last);
        end
        n_checks++;
        if (a_win !== '0) begin
            n_errors++; $display("FAIL reset_a_window: got %h required 0", a_win);
        end
        n_checks++;
        if (a_ir !== 1'b1) begin
            n_errors++; $display("FAIL reset_a_ready: got %b required 1", a_ir);
        end
        n_checks++;
        if (b_ov !== 1'b0 || b_win !== '0) begin
            n_errors++; $display("FAIL reset_b: valid=%b window=%h required 0", b_ov, b_win);
        end
    endtask

    task automatic test_raster;
        logic [7:0] centres [8];
        centres = '{8'h22, 8'h23, 8'h24, 8'h25, 8'h32, 8'h33, 8'h34, 8'h35};
        fill_ramp(8, 6, 8'h00);
        build_expected(8, 6);
        a_got_win.delete(); a_got_last.delete();
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < 8; x++) begin
                send_a(img[y][x]);
                if (y == 4 && x == 3) begin
                    n_checks++;
                    if (a_ov !== 1'b0) begin
                        n_errors++; $display("FAIL raster_early_valid: got %b required 0", a_ov);
                    end
                end
                if (y == 4 && x == 4) begin
                    n_checks++;
                    if (a_ov !== 1'b1 || a_win[7:0] !== 8'h00 || a_win[103:96] !== 8'h22 ||
                        a_win[199:192] !== 8'h44) begin
                        n_errors++;
                        $display("FAIL raster_first_window: valid=%b tl=%h ctr=%h br=%h required 1 00 22 44",
                                 a_ov, a_win[7:0], a_win[103:96], a_win[199:192]);
                    end
                end
            end
        end
        drain(4);
        n_checks++;
        if (a_got_win.size() != 8) begin
            n_errors++; $display("FAIL raster_count: got %0d required 8", a_got_win.size());
        end
        for (int i = 0; i < 8 && i < a_got_win.size(); i++) begin
            n_checks++;
            if (a_got_win[i] !== exp_win[i] || a_got_last[i] !== exp_last[i] ||
                a_got_win[i][103:96] !== centres[i]) begin
                n_errors++;
                $display("FAIL raster_win%0d: got %h last=%b required %h last=%b ctr=%h",
                         i, a_got_win[i], a_got_last[i], exp_win[i], exp_last[i], centres[i]);
            end
        end
    endtask

    task automatic test_stall;
        fill_ramp(8, 6, 8'h00);
        build_expected(8, 6);
        a_got_win.delete(); a_got_last.delete();
        fork
            begin
                for (int y = 0; y < 6; y++)
                    for (int x = 0; x < 8; x++)
                        send_a(img[y][x]);
            end
            begin
                logic [199:0] held_w;
                logic         held_l;
                bit           seen;
                seen = 1'b0;
                for (int t = 0; t < 300 && !seen; t++) begin
                    @(posedge clk);
                    #1;
                    seen = a_ov && (a_got_win.size() >= 1);
                end
                n_checks++;
                if (!seen) begin
                    n_errors++; $display("FAIL stall_trigger: out_valid=%b required 1", a_ov);
                end
                a_or   = 1'b0;
                held_w = a_win;
                held_l = a_last;
                repeat (10) begin
                    @(negedge clk);
                    n_checks++;
                    if (a_ir !== 1'b0 || a_ov !== 1'b1 || a_win !== held_w || a_last !== held_l) begin
                        n_errors++;
                        $display("FAIL stall_hold: ready=%b valid=%b win=%h last=%b required 0 1 %h %b",
                                 a_ir, a_ov, a_win, a_last, held_w, held_l);
                    end
                end
                @(posedge clk);
                #1;
                a_or = 1'b1;
            end
        join
        drain(4);
        n_checks++;
        if (a_got_win.size() != 8) begin
            n_errors++; $display("FAIL stall_count: got %0d required 8", a_got_win.size());
        end
        for (int i = 0; i < 8 && i < a_got_win.size(); i++) begin
            n_checks++;
            if (a_got_win[i] !== exp_win[i] || a_got_last[i] !== exp_last[i]) begin
                n_errors++;
                $display("FAIL stall_win%0d: got %h last=%b required %h last=%b",
                         i, a_got_win[i], a_got_last[i], exp_win[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [199:0] all_win[$];
        logic         all_last[$];
        fill_ramp(8, 6, 8'h00);
        build_expected(8, 6);
        all_win = exp_win; all_last = exp_last;
        a_got_win.delete(); a_got_last.delete();
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 8; x++)
                send_a(img[y][x]);
        fill_ramp(8, 6, 8'h80);
        build_expected(8, 6);
        all_win = {all_win, exp_win}; all_last = {all_last, exp_last};
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 8; x++)
                send_a(img[y][x]);
        drain(4);
        n_checks++;
        if (a_got_win.size() != 16) begin
            n_errors++; $display("FAIL b2b_count: got %0d required 16", a_got_win.size());
        end
        for (int i = 0; i < 16 && i < a_got_win.size(); i++) begin
            n_checks++;
            if (a_got_win[i] !== all_win[i] || a_got_last[i] !== all_last[i]) begin
                n_errors++;
                $display("FAIL b2b_win%0d: got %h last=%b required %h last=%b",
                         i, a_got_win[i], a_got_last[i], all_win[i], all_last[i]);
            end
        end
        for (int i = 8; i < a_got_win.size(); i++) begin
            bit bad;
            bad = 1'b0;
            for (int k = 0; k < 25; k++)
                if (a_got_win[i][8*k+7] !== 1'b1) bad = 1'b1;
            n_checks++;
            if (bad) begin
                n_errors++; $display("FAIL b2b_stale%0d: got %h required all bytes >= 80", i, a_got_win[i]);
            end
        end
        if (a_got_win.size() > 8) begin
            n_checks++;
            if (a_got_win[8][103:96] !== 8'hA2) begin
                n_errors++; $display("FAIL b2b_centre: got %h required a2", a_got_win[8][103:96]);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        fill_ramp(8, 6, 8'h00);
        for (int i = 0; i < 20; i++)
            send_a(img[i/8][i%8]);
        a_rst = 1'b1;
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        n_checks++;
        if (a_ov !== 1'b0 || a_win !== '0) begin
            n_errors++; $display("FAIL midreset_state: valid=%b win=%h required 0 0", a_ov, a_win);
        end
        build_expected(8, 6);
        a_got_win.delete(); a_got_last.delete();
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 8; x++)
                send_a(img[y][x]);
        drain(4);
        n_checks++;
        if (a_got_win.size() != 8) begin
            n_errors++; $display("FAIL midreset_count: got %0d required 8", a_got_win.size());
        end
        for (int i = 0; i < 8 && i < a_got_win.size(); i++) begin
            n_checks++;
            if (a_got_win[i] !== exp_win[i] || a_got_last[i] !== exp_last[i]) begin
                n_errors++;
                $display("FAIL midreset_win%0d: got %h last=%b required %h last=%b",
                         i, a_got_win[i], a_got_last[i], exp_win[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_random;
        for (int y = 0; y < 9; y++)
            for (int x = 0; x < 16; x++)
                img[y][x] = 8'($urandom_range(0, 255));
        build_expected(16, 9);
        b_got_win.delete(); b_got_last.delete();
        b_done = 1'b0;
        fork
            begin
                for (int y = 0; y < 9; y++) begin
                    for (int x = 0; x < 16; x++) begin
                        repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0) begin
                            @(posedge clk);
                            #1;
                        end
                        send_b(img[y][x]);
                    end
                end
                b_done = 1'b1;
            end
            begin
                while (!b_done) begin
                    @(posedge clk);
                    #1;
                    b_or = ($urandom_range(0, 2) != 0);
                end
            end
            begin
                logic [199:0] prev_w;
                logic         prev_l;
                bit           prev_hold;
                prev_hold = 1'b0;
                prev_w = '0;
                prev_l = 1'b0;
                while (!b_done) begin
                    @(negedge clk);
                    if (prev_hold) begin
                        n_checks++;
                        if (b_ov !== 1'b1 || b_win !== prev_w || b_last !== prev_l) begin
                            n_errors++;
                            $display("FAIL random_hold: valid=%b win=%h last=%b required 1 %h %b",
                                     b_ov, b_win, b_last, prev_w, prev_l);
                        end
                    end
                    n_checks++;
                    if (b_ir !== (!b_ov || b_or)) begin
                        n_errors++; $display("FAIL random_ready: got %b required %b", b_ir, !b_ov || b_or);
                    end
                    prev_hold = b_ov && !b_or;
                    prev_w = b_win;
                    prev_l = b_last;
                end
            end
        join
        b_or = 1'b1;
        drain(4);
        n_checks++;
        if (b_got_win.size() != 60) begin
            n_errors++; $display("FAIL random_count: got %0d required 60", b_got_win.size());
        end
        for (int i = 0; i < 60 && i < b_got_win.size(); i++) begin
            n_checks++;
            if (b_got_win[i] !== exp_win[i] || b_got_last[i] !== exp_last[i]) begin
                n_errors++;
                $display("FAIL random_win%0d: got %h last=%b required %h last=%b",
                         i, b_got_win[i], b_got_last[i], exp_win[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_uniform;
        logic [199:0] flat;
        flat = {25{8'h64}};
        a_got_win.delete(); a_got_last.delete();
        for (int i = 0; i < 48; i++)
            send_a(8'd100);
        drain(4);
        n_checks++;
        if (a_got_win.size() != 8) begin
            n_errors++; $display("FAIL uniform_count: got %0d required 8", a_got_win.size());
        end
        for (int i = 0; i < a_got_win.size(); i++) begin
            n_checks++;
            if (a_got_win[i] !== flat) begin
                n_errors++; $display("FAIL uniform_win%0d: got %h required %h", i, a_got_win[i], flat);
            end
        end
    endtask

    initial begin
        test_reset;
        test_raster;
        test_stall;
        test_back_to_back;
        test_reset_mid_frame;
        test_random;
        test_uniform;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
